// File: rtl/goldsmith_pkg.sv
// Shared definitions for the Goldsmith divider and its operand pre-normaliser.
// Operands are Q9.23 unsigned fixed point.
package goldsmith_pkg;

    localparam int WIDTH = 32;
    localparam int FRAC  = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } prenorm_state_t;

    localparam logic [WIDTH-1:0] ONE_HALF = 32'h0040_0000;

endpackage

// File: rtl/goldsmith_prenorm.sv
// Scales dividend and divisor by a common power of two, one bit per clock, until the
// divisor sits in [0.5,1). The quotient is unchanged; feeds goldSmithDiv directly.
module goldsmith_prenorm #(
    parameter int WIDTH = goldsmith_pkg::WIDTH,
    parameter int FRAC  = goldsmith_pkg::FRAC,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] norm_dividend,
    output logic [WIDTH-1:0] norm_divisor,
    output logic [SHW:0]     shift_amt,
    output logic             div_zero,
    output logic             ovf
);
    import goldsmith_pkg::*;

    localparam logic [SHW:0]     SH_ONE = {{SHW{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES   = '1;

    prenorm_state_t   state;
    logic [WIDTH-1:0] dvd, dvs;
    logic [SHW:0]     sh;
    logic             dz, ov;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            dvd   <= '0;
            dvs   <= '0;
            sh    <= '0;
            dz    <= 1'b0;
            ov    <= 1'b0;
        end else if (stop && state != IDLE) begin
            state <= IDLE;
            dvd   <= '0;
            dvs   <= '0;
            sh    <= '0;
            dz    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        sh    <= '0;
                        dz    <= 1'b0;
                        ov    <= 1'b0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (dvs == '0) begin
                        dz    <= 1'b1;
                        dvd   <= ONES;
                        dvs   <= '0;
                        state <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (dvs[WIDTH-1:FRAC] != '0) begin
                        dvd <= dvd >> 1;
                        dvs <= dvs >> 1;
                        sh  <= sh - SH_ONE;
                    end else if (!dvs[FRAC-1]) begin
                        dvs <= dvs << 1;
                        sh  <= sh + SH_ONE;
                        // Once the dividend has lost its MSB it stays saturated.
                        if (ov || dvd[WIDTH-1]) begin
                            ov  <= 1'b1;
                            dvd <= ONES;
                        end else begin
                            dvd <= dvd << 1;
                        end
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign norm_dividend = dvd;
    assign norm_divisor  = dvs;
    assign shift_amt     = sh;
    assign div_zero      = dz;
    assign ovf           = ov;

endmodule

// File: tb/tb_goldsmith_prenorm.sv
// Table-driven bench for goldsmith_prenorm with a scoreboard queue, plus abort/reset sequences.
module tb_goldsmith_prenorm;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_zero, ovf;
    logic [31:0] norm_dividend, norm_divisor;
    logic [6:0]  shift_amt;

    goldsmith_prenorm dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .norm_dividend(norm_dividend), .norm_divisor(norm_divisor),
        .shift_amt(shift_amt), .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        int          lat;
        logic [31:0] e_dvd;
        logic [31:0] e_dvs;
        int          e_sh;
        logic        e_dz;
        logic        e_ov;
    } vec_t;

    vec_t vecs[7];
    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_dvd"}, norm_dividend, 32'd0);
        chk({tag, "_dvs"}, norm_divisor, 32'd0);
        chk({tag, "_sh"}, 32'(shift_amt), 32'd0);
        chk({tag, "_flags"}, {30'd0, div_zero, ovf}, 32'd0);
    endtask

    // Drive one operation; optionally pulse start with other operands while busy.
    task automatic run_op(input vec_t v, input bit pulse_busy, input string tag);
        vec_t e;
        int   edges;
        @(negedge clk);
        dividend = v.dvd;
        divisor  = v.dvs;
        start    = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1 start = 1'b0;
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
            if (pulse_busy && edges == 2) begin
                start    = 1'b1;
                divisor  = 32'd0;
                dividend = 32'h1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_latency"}, 32'(edges), 32'(e.lat));
        chk({tag, "_norm_dividend"}, norm_dividend, e.e_dvd);
        chk({tag, "_norm_divisor"}, norm_divisor, e.e_dvs);
        chk({tag, "_shift_amt"}, 32'($signed(shift_amt)), 32'(e.e_sh));
        chk({tag, "_div_zero"}, 32'(div_zero), 32'(e.e_dz));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.e_ov));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold_dvs"}, norm_divisor, e.e_dvs);
    endtask

    initial begin
        int seen;
        vecs[0] = '{32'h0080_0000, 32'h0040_0000,  2, 32'h0080_0000, 32'h0040_0000,  0, 1'b0, 1'b0};
        vecs[1] = '{32'h0080_0000, 32'h0280_0000,  5, 32'h0010_0000, 32'h0050_0000, -3, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0800, 32'h0000_1000, 12, 32'h0020_0000, 32'h0040_0000, 10, 1'b0, 1'b0};
        vecs[3] = '{32'h0100_0000, 32'h0000_1000, 12, 32'hFFFF_FFFF, 32'h0040_0000, 10, 1'b0, 1'b1};
        vecs[4] = '{32'h0000_0005, 32'h0000_0000,  1, 32'hFFFF_FFFF, 32'h0000_0000,  0, 1'b1, 1'b0};
        vecs[5] = '{32'h1234_5678, 32'hFFFF_FFFF, 11, 32'h0009_1A2B, 32'h007F_FFFF, -9, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0003, 32'h0000_0001, 24, 32'h00C0_0000, 32'h0040_0000, 22, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; stop = 1'b0; dividend = '0; divisor = '0;
        #1;
        check_cleared("reset");
        chk("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 7; i++) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // start while busy must not disturb the running operation
        run_op(vecs[1], 1'b1, "busy_start");

        // stop on the second SHIFT cycle of the 5.0 divisor case
        @(negedge clk);
        dividend = 32'h0080_0000; divisor = 32'h0280_0000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        check_cleared("stop");
        chk("stop_done", 32'(done), 32'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        chk("stop_no_done", 32'(seen), 32'd0);

        // stop and start together in IDLE: nothing captured
        @(negedge clk);
        dividend = 32'h0080_0000; divisor = 32'h0040_0000; start = 1'b1; stop = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; stop = 1'b0; end
        chk("stop_start_busy", 32'(busy), 32'd0);
        chk("stop_start_dvs", norm_divisor, 32'd0);

        // asynchronous reset in the middle of SHIFT
        @(negedge clk);
        dividend = 32'h0000_0800; divisor = 32'h0000_1000; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_cleared("mid_reset");
        @(negedge clk) reset = 1'b0;

        // normal operation after the reset
        run_op(vecs[2], 1'b0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
